voice_mixer: RTL

VOICE_MIXER -- requirements
Module: voice_mixer

---
 rtl/voice_mixer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/voice_mixer.sv
// Time-multiplexed voice mixer: sums NUM_VOICES slot samples per frame, scales by
// an arithmetic shift, saturates to 16 bits and offers the result on a valid/ready port.
module voice_mixer #(
  parameter int NUM_VOICES = 10,
  parameter int SHIFT      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] i_signal,
  input  logic        [3:0]  i_idx,
  input  logic               i_ready,
  output logic signed [15:0] o_sample,
  output logic               o_valid,
  output logic        [3:0]  o_active,
  output logic               o_err,
  output logic               o_overrun
);

  typedef enum logic {SYNC, ACC} state_t;

  localparam logic [3:0] LAST = 4'(NUM_VOICES - 1);

  state_t             state_q, state_d;
  logic signed [19:0] acc_q, acc_d;
  logic        [4:0]  cnt_q, cnt_d;
  logic        [3:0]  exp_q, exp_d;
  logic               done_d;
  logic               err_d;

  logic signed [19:0] sig_ext;
  logic               nonzero;
  logic signed [19:0] fin_sum;
  logic        [4:0]  fin_cnt;
  logic signed [19:0] shifted;
  logic signed [15:0] sat_sample;
  logic        [3:0]  sat_active;

  assign sig_ext = {{4{i_signal[15]}}, i_signal};
  assign nonzero = (i_signal != 16'sd0);
  assign fin_sum = acc_q + sig_ext;
  assign fin_cnt = cnt_q + {4'b0000, nonzero};

  // The 20-bit sum is shifted at full width so no precision is lost before clamping.
  always_comb begin
    shifted = fin_sum >>> SHIFT;
    if (shifted > 20'sd32767) begin
      sat_sample = 16'sh7FFF;
    end else if (shifted < -20'sd32768) begin
      sat_sample = 16'sh8000;
    end else begin
      sat_sample = shifted[15:0];
    end
    sat_active = (fin_cnt > 5'd15) ? 4'd15 : fin_cnt[3:0];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      SYNC: begin
        if (i_idx == 4'd0) begin
          acc_d   = sig_ext;
          cnt_d   = {4'b0000, nonzero};
          exp_d   = 4'd1;
          state_d = ACC;
        end
      end
      ACC: begin
        if (i_idx == exp_q) begin
          if (exp_q == LAST) begin
            done_d  = 1'b1;
            exp_d   = 4'd0;
            state_d = SYNC;
          end else begin
            acc_d = fin_sum;
            cnt_d = fin_cnt;
            exp_d = exp_q + 4'd1;
          end
        end else begin
          // A broken sequence drops the partial frame; slot 0 starts a fresh one at once.
          err_d   = 1'b1;
          exp_d   = 4'd0;
          state_d = SYNC;
          if (i_idx == 4'd0) begin
            acc_d   = sig_ext;
            cnt_d   = {4'b0000, nonzero};
            exp_d   = 4'd1;
            state_d = ACC;
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= SYNC;
      acc_q     <= '0;
      cnt_q     <= '0;
      exp_q     <= '0;
      o_sample  <= '0;
      o_active  <= '0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      o_err     <= err_d;
      o_overrun <= 1'b0;
      // A completed frame replaces the held one only if it is free or consumed now.
      if (done_d) begin
        if (!o_valid || i_ready) begin
          o_sample <= sat_sample;
          o_active <= sat_active;
          o_valid  <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
